// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared CPU definitions: default bus widths, register-file
//             arbiter state encoding and requester index constants.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 8;

    // Register-file arbiter ownership states
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    // Requester slot indices on the packed request buses
    localparam int REQ_CU  = 0;
    localparam int REQ_DBG = 1;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/arb_hold_counter.sv
`default_nettype none
// ============================================================================
//  Module   : arb_hold_counter
//  Purpose  : Saturating access counter for the arbiter's grant-hold limit.
//             Clear has priority over increment; at_limit_o flags that the
//             count has reached MAX_HOLD-1.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_hold_counter #(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam int                 CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0]   LIMIT = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] count_q;

    // Count accesses, clearing on ownership change and saturating at LIMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != LIMIT)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign at_limit_o = (count_q == LIMIT);

endmodule : arb_hold_counter
`default_nettype wire

// File: rtl/reg_file_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_arbiter
//  Purpose  : Round-robin arbiter sharing the register-file port between the
//             ControlUnit (slot 0) and the debug/program loader (slot 1),
//             with a bounded grant-hold and read-data return routing.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] adr1,
    input  logic [2*ADDR_W-1:0] adr2,
    input  logic [2*ADDR_W-1:0] adr3,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [DATA_W-1:0]   rdata1,
    output logic [DATA_W-1:0]   rdata2,
    output logic [ADDR_W-1:0]   ADR_1,
    output logic [ADDR_W-1:0]   ADR_2,
    output logic [ADDR_W-1:0]   ADR_3,
    output logic [DATA_W-1:0]   write_data,
    output logic                regWriteEnable,
    output logic                regReadEnable,
    input  logic [DATA_W-1:0]   rf_rdata1,
    input  logic [DATA_W-1:0]   rf_rdata2
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_owner_q;
    logic [1:0] gnt_q;
    logic [1:0] rvalid_q;

    logic              w_owner;      // 1 when slot 1 owns, 0 when slot 0 owns
    logic              w_own_any;
    logic              w_access;
    logic              w_other_req;
    logic              w_wr;
    logic              w_rd;
    logic              w_at_limit;
    logic              w_state_change;
    logic [ADDR_W-1:0] w_sel_adr1;
    logic [ADDR_W-1:0] w_sel_adr2;
    logic [ADDR_W-1:0] w_sel_adr3;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_owner     = (state_q == ARB_OWN1);
    assign w_own_any   = (state_q == ARB_OWN0) || (state_q == ARB_OWN1);
    assign w_access    = w_own_any && req[w_owner];
    assign w_other_req = req[~w_owner];
    assign w_wr        = w_access && we[w_owner];
    assign w_rd        = w_access && !we[w_owner];

    assign w_sel_adr1  = w_owner ? adr1[2*ADDR_W-1:ADDR_W]  : adr1[ADDR_W-1:0];
    assign w_sel_adr2  = w_owner ? adr2[2*ADDR_W-1:ADDR_W]  : adr2[ADDR_W-1:0];
    assign w_sel_adr3  = w_owner ? adr3[2*ADDR_W-1:ADDR_W]  : adr3[ADDR_W-1:0];
    assign w_sel_wdata = w_owner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

    // Register-file port is driven only during an actual access, else all zero
    assign regWriteEnable = w_wr;
    assign regReadEnable  = w_rd;
    assign ADR_1          = w_rd ? w_sel_adr1  : '0;
    assign ADR_2          = w_rd ? w_sel_adr2  : '0;
    assign ADR_3          = w_wr ? w_sel_adr3  : '0;
    assign write_data     = w_wr ? w_sel_wdata : '0;

    // Next ownership: round-robin on ties, hand over on drop or hold limit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (req[REQ_CU] && req[REQ_DBG]) begin
                    state_d = last_owner_q ? ARB_OWN0 : ARB_OWN1;
                end else if (req[REQ_CU]) begin
                    state_d = ARB_OWN0;
                end else if (req[REQ_DBG]) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0: begin
                if (!req[REQ_CU]) begin
                    state_d = req[REQ_DBG] ? ARB_OWN1 : ARB_IDLE;
                end else if (req[REQ_DBG] && w_at_limit) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN1: begin
                if (!req[REQ_DBG]) begin
                    state_d = req[REQ_CU] ? ARB_OWN0 : ARB_IDLE;
                end else if (req[REQ_CU] && w_at_limit) begin
                    state_d = ARB_OWN0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign w_state_change = (state_d != state_q);

    // Hold count only advances while the other side is actually waiting
    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (w_state_change),
        .inc_i      (w_access && w_other_req),
        .at_limit_o (w_at_limit)
    );

    // Ownership state, round-robin history, grant and read-return registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= 1'b1;
            gnt_q        <= 2'b00;
            rvalid_q     <= 2'b00;
        end else begin
            state_q  <= state_d;
            gnt_q    <= {state_d == ARB_OWN1, state_d == ARB_OWN0};
            rvalid_q <= {w_rd && w_owner, w_rd && !w_owner};
            if (w_state_change) begin
                if (state_d == ARB_OWN0) begin
                    last_owner_q <= 1'b0;
                end else if (state_d == ARB_OWN1) begin
                    last_owner_q <= 1'b1;
                end
            end
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    // The register file's read port is itself registered; gating it with the
    // registered valid keeps the data zero whenever no read is returning.
    assign rdata1 = (|rvalid_q) ? rf_rdata1 : '0;
    assign rdata2 = (|rvalid_q) ? rf_rdata2 : '0;

endmodule : reg_file_arbiter
`default_nettype wire

// File: tb/tb_reg_file_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_arbiter
//  Purpose  : Directed self-checking bench for reg_file_arbiter with a small
//             synchronous register-file model attached to the shared port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] adr1, adr2, adr3, wdata;
    logic [1:0]  gnt, rvalid;
    logic [7:0]  rdata1, rdata2;
    logic [7:0]  ADR_1, ADR_2, ADR_3, write_data;
    logic        regWriteEnable, regReadEnable;
    logic [7:0]  rf_rdata1, rf_rdata2;

    int checks = 0;
    int errors = 0;

    reg_file_arbiter #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .MAX_HOLD (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .we             (we),
        .adr1           (adr1),
        .adr2           (adr2),
        .adr3           (adr3),
        .wdata          (wdata),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata1         (rdata1),
        .rdata2         (rdata2),
        .ADR_1          (ADR_1),
        .ADR_2          (ADR_2),
        .ADR_3          (ADR_3),
        .write_data     (write_data),
        .regWriteEnable (regWriteEnable),
        .regReadEnable  (regReadEnable),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: synchronous write and registered read; reset preloads reg3/reg5
    logic [7:0] rf_mem [256];
    always @(posedge clk) begin
        if (rst) begin
            rf_mem[3] <= 8'h11;
            rf_mem[5] <= 8'h22;
            rf_rdata1 <= 8'h00;
            rf_rdata2 <= 8'h00;
        end else begin
            if (regWriteEnable) rf_mem[ADR_3] <= write_data;
            if (regReadEnable) begin
                rf_rdata1 <= rf_mem[ADR_1];
                rf_rdata2 <= rf_mem[ADR_2];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive0(input logic r, input logic w, input logic [7:0] a1,
                          input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] d);
        req[0] = r; we[0] = w; adr1[7:0] = a1; adr2[7:0] = a2; adr3[7:0] = a3; wdata[7:0] = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [7:0] a1,
                          input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] d);
        req[1] = r; we[1] = w; adr1[15:8] = a1; adr2[15:8] = a2; adr3[15:8] = a3; wdata[15:8] = d;
    endtask

    task automatic do_reset();
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b expected 00", gnt); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b expected 00", rvalid); end
        checks++; if ({rdata1, rdata2} !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h expected 0000", {rdata1, rdata2}); end
        checks++; if ({regWriteEnable, regReadEnable, ADR_1, ADR_2, ADR_3, write_data} !== 34'h0) begin
            errors++; $display("FAIL reset_rf_port got %h expected 0", {regWriteEnable, regReadEnable, ADR_1, ADR_2, ADR_3, write_data}); end
        cyc(); cyc();
        checks++; if (gnt !== 2'b00 || regReadEnable !== 1'b0) begin errors++; $display("FAIL idle_gnt got %b/%b expected 00/0", gnt, regReadEnable); end
    endtask

    task automatic test_single_read();
        drive0(1, 0, 8'd3, 8'd5, 0, 0);
        #1;
        checks++; if (gnt !== 2'b00 || regReadEnable !== 1'b0) begin errors++; $display("FAIL sr_pregrant got %b/%b expected 00/0", gnt, regReadEnable); end
        cyc(); #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL sr_gnt got %b expected 01", gnt); end
        checks++; if (regReadEnable !== 1'b1 || ADR_1 !== 8'd3 || ADR_2 !== 8'd5 || regWriteEnable !== 1'b0) begin
            errors++; $display("FAIL sr_port got re=%b a1=%0d a2=%0d we=%b expected re=1 a1=3 a2=5 we=0", regReadEnable, ADR_1, ADR_2, regWriteEnable); end
        cyc();
        drive0(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (rvalid !== 2'b01 || rdata1 !== 8'h11 || rdata2 !== 8'h22) begin
            errors++; $display("FAIL sr_return got rv=%b d1=%h d2=%h expected rv=01 d1=11 d2=22", rvalid, rdata1, rdata2); end
        cyc(); #1;
        checks++; if (gnt !== 2'b00 || rvalid !== 2'b00 || rdata1 !== 8'h00) begin
            errors++; $display("FAIL sr_release got gnt=%b rv=%b d1=%h expected 00/00/00", gnt, rvalid, rdata1); end
    endtask

    task automatic test_tie_handover();
        do_reset();
        drive0(1, 0, 0, 0, 0, 0);
        drive1(1, 0, 0, 0, 0, 0);
        cyc(); #1;
        checks++; if (gnt !== 2'b01 || regReadEnable !== 1'b1) begin errors++; $display("FAIL tie_first got gnt=%b re=%b expected 01/1", gnt, regReadEnable); end
        cyc();
        drive0(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (gnt !== 2'b01 || rvalid !== 2'b01 || regReadEnable !== 1'b0) begin
            errors++; $display("FAIL tie_drop got gnt=%b rv=%b re=%b expected 01/01/0", gnt, rvalid, regReadEnable); end
        cyc(); #1;
        checks++; if (gnt !== 2'b10 || regReadEnable !== 1'b1) begin errors++; $display("FAIL tie_handover got gnt=%b re=%b expected 10/1", gnt, regReadEnable); end
        cyc();
        drive1(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL tie_rv1 got %b expected 10", rvalid); end
        cyc(); cyc(); #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL tie_idle got %b expected 00", gnt); end
    endtask

    task automatic test_hold_fairness();
        logic [1:0] exp_gnt [14];
        logic [7:0] exp_d;
        int wi;
        exp_gnt = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                    2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        wi = 0;
        for (int c = 0; c < 14; c++) begin
            exp_d = 8'hA0 + 8'(wi);
            drive0(wi < 8, 1, 0, 0, 8'd7, exp_d);
            drive1(1, 0, 8'd0, 8'd0, 0, 0);
            #1;
            checks++; if (gnt !== exp_gnt[c]) begin errors++; $display("FAIL hold_gnt cycle %0d got %b expected %b", c, gnt, exp_gnt[c]); end
            if (c == 5) begin
                checks++; if (wi !== 4) begin errors++; $display("FAIL hold_first_burst got %0d writes expected 4", wi); end
            end
            if (regWriteEnable) begin
                checks++; if (ADR_3 !== 8'd7 || write_data !== exp_d) begin
                    errors++; $display("FAIL hold_write cycle %0d got a3=%0d d=%h expected a3=7 d=%h", c, ADR_3, write_data, exp_d); end
                wi++;
            end
            cyc();
        end
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        checks++; if (wi !== 8) begin errors++; $display("FAIL hold_total got %0d writes expected 8", wi); end
        cyc(); cyc(); #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL hold_idle got %b expected 00", gnt); end
    endtask

    task automatic test_read_handover();
        // last owner is slot 1 here, so slot 0 wins the tie
        drive0(1, 0, 8'd3, 8'd5, 0, 0);
        drive1(1, 1, 0, 0, 8'd9, 8'h77);
        for (int c = 0; c < 5; c++) cyc();
        drive0(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rh_gnt got %b expected 10", gnt); end
        checks++; if (rvalid !== 2'b01 || rdata1 !== 8'h11 || rdata2 !== 8'h22) begin
            errors++; $display("FAIL rh_return got rv=%b d1=%h d2=%h expected 01/11/22", rvalid, rdata1, rdata2); end
        checks++; if (regWriteEnable !== 1'b1 || ADR_3 !== 8'd9 || write_data !== 8'h77) begin
            errors++; $display("FAIL rh_write got we=%b a3=%0d d=%h expected 1/9/77", regWriteEnable, ADR_3, write_data); end
        cyc();
        drive1(0, 0, 0, 0, 0, 0);
        cyc(); cyc(); #1;
        checks++; if (gnt !== 2'b00 || rvalid !== 2'b00) begin errors++; $display("FAIL rh_idle got gnt=%b rv=%b expected 00/00", gnt, rvalid); end
    endtask

    task automatic test_write_then_read();
        drive1(1, 1, 0, 0, 8'd2, 8'h5C);
        cyc(); #1;
        checks++; if (gnt !== 2'b10 || regWriteEnable !== 1'b1 || ADR_3 !== 8'd2 || write_data !== 8'h5C) begin
            errors++; $display("FAIL wr_write got gnt=%b we=%b a3=%0d d=%h expected 10/1/2/5c", gnt, regWriteEnable, ADR_3, write_data); end
        cyc();
        drive1(1, 0, 8'd2, 8'd9, 0, 0);
        #1;
        checks++; if (regReadEnable !== 1'b1 || ADR_1 !== 8'd2 || ADR_2 !== 8'd9 || ADR_3 !== 8'd0) begin
            errors++; $display("FAIL wr_read got re=%b a1=%0d a2=%0d a3=%0d expected 1/2/9/0", regReadEnable, ADR_1, ADR_2, ADR_3); end
        cyc();
        drive1(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (rvalid !== 2'b10 || rdata1 !== 8'h5C || rdata2 !== 8'h77) begin
            errors++; $display("FAIL wr_return got rv=%b d1=%h d2=%h expected 10/5c/77", rvalid, rdata1, rdata2); end
        cyc(); cyc(); #1;
        checks++; if (gnt !== 2'b00 || rvalid !== 2'b00) begin errors++; $display("FAIL wr_idle got gnt=%b rv=%b expected 00/00", gnt, rvalid); end
    endtask

    task automatic test_reset_mid();
        drive0(1, 0, 8'd3, 8'd5, 0, 0);
        cyc(); #1;
        checks++; if (gnt !== 2'b01 || regReadEnable !== 1'b1) begin errors++; $display("FAIL rm_setup got gnt=%b re=%b expected 01/1", gnt, regReadEnable); end
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 2'b00 || rvalid !== 2'b00 || regReadEnable !== 1'b0) begin
            errors++; $display("FAIL rm_async got gnt=%b rv=%b re=%b expected 00/00/0", gnt, rvalid, regReadEnable); end
        for (int c = 0; c < 3; c++) begin
            cyc(); #1;
            checks++; if (gnt !== 2'b00 || rvalid !== 2'b00 || regReadEnable !== 1'b0) begin
                errors++; $display("FAIL rm_hold cycle %0d got gnt=%b rv=%b re=%b expected 00/00/0", c, gnt, rvalid, regReadEnable); end
        end
        drive0(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(); #1;
        checks++; if (gnt !== 2'b00 || rvalid !== 2'b00 || rdata1 !== 8'h00) begin
            errors++; $display("FAIL rm_after got gnt=%b rv=%b d1=%h expected 00/00/00", gnt, rvalid, rdata1); end
    endtask

    initial begin
        rst = 1'b1;
        req = '0; we = '0; adr1 = '0; adr2 = '0; adr3 = '0; wdata = '0;
        test_reset();
        test_single_read();
        test_tie_handover();
        test_hold_fairness();
        test_read_handover();
        test_write_then_read();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout got no completion expected finish");
        $fatal(1);
    end

endmodule : tb_reg_file_arbiter
`default_nettype wire
